// File: rtl/int_div_pkg.sv
// Shared constants and helpers for the programmable integer divider.
// Divisor 0 mutes the output; divisor 1 behaves as divisor 2.
package int_div_pkg;

    localparam logic [31:0] DIV_MUTE = 32'd0;
    localparam logic [31:0] DIV_MIN  = 32'd2;

    // Clamp a raw divisor: mute stays 0, anything below the minimum becomes it.
    function automatic logic [31:0] eff_div(input logic [31:0] d);
        if (d != DIV_MUTE && d < DIV_MIN)
            return DIV_MIN;
        return d;
    endfunction

endpackage

// File: rtl/div_half_ext.sv
// Half-cycle extender for odd divisors: negedge copy of q_pos ORed in.
// Present only in builds with PROG_INT_DIV_ODD_FIX_EN defined.
module div_half_ext (
    input  logic clk,
    input  logic rst_n,
    input  logic q_pos,
    input  logic odd,
    output logic clockout
);

    logic q_neg;

    // Delay q_pos by half a clock so odd periods get the extra half cycle high.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)
            q_neg <= 1'b0;
        else
            q_neg <= q_pos;
    end

    assign clockout = odd ? (q_pos | q_neg) : q_pos;

endmodule

// File: rtl/prog_int_div.sv
// Runtime-programmable integer clock divider with glitch-free divisor reload.
// Define PROG_INT_DIV_ODD_FIX_EN for exact 50% duty on odd divisors.
module prog_int_div
    import int_div_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 1000
) (
    input  logic             clockin,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    output logic             clockout,
    output logic [WIDTH-1:0] cnt,
    output logic             tick,
    output logic             load_pending
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] div_cur;
    logic [WIDTH-1:0] div_pend;
    logic             running;
    logic             q_pos;

    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] cand_div;
    logic [WIDTH-1:0] nxt_div;
    logic [WIDTH-1:0] nxt_n;
    logic [WIDTH-1:0] nxt_cnt;
    logic             run;
    logic             at_last;
    logic             boundary;
    logic             nxt_q;

    // Period decode, boundary detection and next-state values.
    always_comb begin
        run      = en && (div_cur != WIDTH'(DIV_MUTE));
        n        = WIDTH'(eff_div(32'(div_cur)));
        at_last  = running && (cnt == n - WIDTH'(1));
        boundary = !run || !running || at_last;
        cand_div = load ? div_in : (load_pending ? div_pend : div_cur);
        nxt_div  = boundary ? cand_div : div_cur;
        nxt_n    = WIDTH'(eff_div(32'(nxt_div)));
        nxt_cnt  = boundary ? '0 : cnt + WIDTH'(1);
        nxt_q    = run && (nxt_cnt < (nxt_n >> 1));
        tick     = run && at_last;
    end

    // Divisor capture: apply at a boundary, otherwise hold as pending.
    always_ff @(posedge clockin or negedge rst_n) begin
        if (!rst_n) begin
            div_cur      <= DIV_RST;
            div_pend     <= '0;
            load_pending <= 1'b0;
        end else if (boundary) begin
            div_cur      <= cand_div;
            load_pending <= 1'b0;
        end else if (load) begin
            div_pend     <= div_in;
            load_pending <= 1'b1;
        end
    end

    // Phase counter and posedge output register.
    always_ff @(posedge clockin or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            running <= 1'b0;
            q_pos   <= 1'b0;
        end else if (run) begin
            cnt     <= nxt_cnt;
            running <= 1'b1;
            q_pos   <= nxt_q;
        end else begin
            cnt     <= '0;
            running <= 1'b0;
            q_pos   <= 1'b0;
        end
    end

`ifdef PROG_INT_DIV_ODD_FIX_EN
    div_half_ext u_ext (
        .clk      (clockin),
        .rst_n    (rst_n),
        .q_pos    (q_pos),
        .odd      (n[0]),
        .clockout (clockout)
    );
`else
    assign clockout = q_pos;
`endif

endmodule

// File: tb/tb_prog_int_div.sv
// Directed self-checking bench for prog_int_div (DEFAULT_DIV = 4).
// Expectations follow the build's PROG_INT_DIV_ODD_FIX_EN setting.
module tb_prog_int_div;

    logic        clockin;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] div_in;
    logic        clockout;
    logic [15:0] cnt;
    logic        tick;
    logic        load_pending;

    int checks = 0;
    int errors = 0;

`ifdef PROG_INT_DIV_ODD_FIX_EN
    localparam bit FIX = 1'b1;
`else
    localparam bit FIX = 1'b0;
`endif

    prog_int_div #(
        .WIDTH       (16),
        .DEFAULT_DIV (4)
    ) dut (
        .clockin      (clockin),
        .rst_n        (rst_n),
        .en           (en),
        .load         (load),
        .div_in       (div_in),
        .clockout     (clockout),
        .cnt          (cnt),
        .tick         (tick),
        .load_pending (load_pending)
    );

    initial clockin = 1'b0;
    always #5 clockin = ~clockin;

    task automatic step();
        @(posedge clockin);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        en     = 1'b1;
        load   = 1'b0;
        div_in = 16'd0;
        repeat (3) @(posedge clockin);
        #1;
        checks++;
        if (cnt !== 16'd0 || clockout !== 1'b0 || tick !== 1'b0 ||
            load_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: cnt=%0d clk=%b tick=%b pend=%b, required all 0",
                     cnt, clockout, tick, load_pending);
        end
        @(negedge clockin);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (cnt !== 16'(i % 4) || clockout !== 1'((i % 4) < 2) ||
                tick !== 1'((i % 4) == 3)) begin
                errors++;
                $display("FAIL div4_cycle%0d: cnt=%0d clk=%b tick=%b, required cnt=%0d clk=%b tick=%b",
                         i, cnt, clockout, tick, i % 4, (i % 4) < 2, (i % 4) == 3);
            end
        end
    endtask

    task automatic test_odd_div();
        logic ep [5];
        logic en_s [5];
        if (FIX) begin
            ep   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            en_s = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        end else begin
            ep   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            en_s = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        end
        load   = 1'b1;
        div_in = 16'd5;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) load = 1'b0;
            checks++;
            if (cnt !== 16'(i % 5) || clockout !== ep[i % 5] ||
                load_pending !== 1'b0) begin
                errors++;
                $display("FAIL div5_pos%0d: cnt=%0d clk=%b pend=%b, required cnt=%0d clk=%b pend=0",
                         i, cnt, clockout, load_pending, i % 5, ep[i % 5]);
            end
            @(negedge clockin);
            #1;
            checks++;
            if (clockout !== en_s[i % 5]) begin
                errors++;
                $display("FAIL div5_neg%0d: clk=%b, required %b",
                         i, clockout, en_s[i % 5]);
            end
        end
    endtask

    task automatic test_pending_load();
        load   = 1'b1;
        div_in = 16'd4;
        step();
        load = 1'b0;
        checks++;
        if (cnt !== 16'd0 || load_pending !== 1'b0) begin
            errors++;
            $display("FAIL reload4: cnt=%0d pend=%b, required cnt=0 pend=0",
                     cnt, load_pending);
        end
        step();
        load   = 1'b1;
        div_in = 16'd6;
        step();
        load = 1'b0;
        checks++;
        if (cnt !== 16'd2 || load_pending !== 1'b1 || clockout !== 1'b0) begin
            errors++;
            $display("FAIL pend_mid: cnt=%0d pend=%b clk=%b, required cnt=2 pend=1 clk=0",
                     cnt, load_pending, clockout);
        end
        step();
        checks++;
        if (cnt !== 16'd3 || load_pending !== 1'b1 || tick !== 1'b1) begin
            errors++;
            $display("FAIL pend_last: cnt=%0d pend=%b tick=%b, required cnt=3 pend=1 tick=1",
                     cnt, load_pending, tick);
        end
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (cnt !== 16'(i % 6) || clockout !== 1'((i % 6) < 3) ||
                tick !== 1'((i % 6) == 5) || load_pending !== 1'b0) begin
                errors++;
                $display("FAIL div6_cycle%0d: cnt=%0d clk=%b tick=%b pend=%b, required cnt=%0d clk=%b tick=%b pend=0",
                         i, cnt, clockout, tick, load_pending,
                         i % 6, (i % 6) < 3, (i % 6) == 5);
            end
        end
    endtask

    task automatic test_double_load();
        logic exp_clk;
        load   = 1'b1;
        div_in = 16'd7;
        step();
        div_in = 16'd9;
        step();
        load = 1'b0;
        checks++;
        if (cnt !== 16'd2 || load_pending !== 1'b1) begin
            errors++;
            $display("FAIL dbl_pend: cnt=%0d pend=%b, required cnt=2 pend=1",
                     cnt, load_pending);
        end
        repeat (3) step();
        for (int i = 0; i < 10; i++) begin
            step();
            exp_clk = ((i % 9) < 4) || (FIX && (i % 9) == 4);
            checks++;
            if (cnt !== 16'(i % 9) || tick !== 1'((i % 9) == 8) ||
                clockout !== exp_clk) begin
                errors++;
                $display("FAIL div9_cycle%0d: cnt=%0d tick=%b clk=%b, required cnt=%0d tick=%b clk=%b",
                         i, cnt, tick, clockout, i % 9, (i % 9) == 8, exp_clk);
            end
        end
    endtask

    task automatic test_mute();
        logic exp_clk;
        load   = 1'b1;
        div_in = 16'd0;
        step();
        load = 1'b0;
        checks++;
        if (cnt !== 16'd1 || load_pending !== 1'b1 || clockout !== 1'b1) begin
            errors++;
            $display("FAIL mute_pend: cnt=%0d pend=%b clk=%b, required cnt=1 pend=1 clk=1",
                     cnt, load_pending, clockout);
        end
        repeat (8) step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cnt !== 16'd0 || clockout !== 1'b0 || tick !== 1'b0 ||
                load_pending !== 1'b0) begin
                errors++;
                $display("FAIL muted%0d: cnt=%0d clk=%b tick=%b pend=%b, required all 0",
                         i, cnt, clockout, tick, load_pending);
            end
            step();
        end
        load   = 1'b1;
        div_in = 16'd3;
        step();
        load = 1'b0;
        checks++;
        if (cnt !== 16'd0 || load_pending !== 1'b0) begin
            errors++;
            $display("FAIL unmute_load: cnt=%0d pend=%b, required cnt=0 pend=0",
                     cnt, load_pending);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            exp_clk = ((i % 3) == 0) || (FIX && (i % 3) == 1);
            checks++;
            if (cnt !== 16'(i % 3) || tick !== 1'((i % 3) == 2) ||
                clockout !== exp_clk) begin
                errors++;
                $display("FAIL div3_cycle%0d: cnt=%0d tick=%b clk=%b, required cnt=%0d tick=%b clk=%b",
                         i, cnt, tick, clockout, i % 3, (i % 3) == 2, exp_clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        load   = 1'b1;
        div_in = 16'd9;
        step();
        load = 1'b0;
        step();
        load   = 1'b1;
        div_in = 16'd5;
        step();
        load = 1'b0;
        checks++;
        if (cnt !== 16'd2 || load_pending !== 1'b1 || clockout !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: cnt=%0d pend=%b clk=%b, required cnt=2 pend=1 clk=1",
                     cnt, load_pending, clockout);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cnt !== 16'd0 || clockout !== 1'b0 || tick !== 1'b0 ||
            load_pending !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d clk=%b tick=%b pend=%b, required all 0",
                     cnt, clockout, tick, load_pending);
        end
        repeat (2) @(posedge clockin);
        @(negedge clockin);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (cnt !== 16'(i % 4) || tick !== 1'((i % 4) == 3) ||
                clockout !== 1'((i % 4) < 2)) begin
                errors++;
                $display("FAIL post_reset%0d: cnt=%0d tick=%b clk=%b, required cnt=%0d tick=%b clk=%b",
                         i, cnt, tick, clockout, i % 4, (i % 4) == 3, (i % 4) < 2);
            end
        end
    endtask

    task automatic test_stop();
        step();
        en = 1'b0;
        step();
        checks++;
        if (cnt !== 16'd0 || clockout !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL stop: cnt=%0d clk=%b tick=%b, required all 0",
                     cnt, clockout, tick);
        end
        repeat (3) step();
        checks++;
        if (cnt !== 16'd0 || clockout !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL stopped: cnt=%0d clk=%b tick=%b, required all 0",
                     cnt, clockout, tick);
        end
    endtask

    initial begin
        test_reset();
        test_odd_div();
        test_pending_load();
        test_double_load();
        test_mute();
        test_reset_mid();
        test_stop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
